// File: rtl/imm_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_enc: packs a signed immediate into an instruction template and       |
// | queues {inst, err} in a 2-entry FIFO.          Revision: 1.0             |
// +--------------------------------------------------------------------------+
module imm_enc (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [31:0] io_in_base,
  input  logic [31:0] io_in_imm,
  input  logic [2:0]  io_in_sel,
  input  logic        io_flush,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_inst,
  output logic        io_out_err,
  output logic [7:0]  io_err_cnt
);

  localparam logic [2:0] SEL_I = 3'd1;
  localparam logic [2:0] SEL_S = 3'd2;
  localparam logic [2:0] SEL_U = 3'd3;
  localparam logic [2:0] SEL_J = 3'd4;
  localparam logic [2:0] SEL_B = 3'd5;
  localparam logic [2:0] SEL_Z = 3'd6;

  logic [31:0] enc_inst;
  logic        enc_err;

  logic [31:0] inst_q [2];
  logic [31:0] inst_d [2];
  logic [1:0]  err_q, err_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        push, pop;

  // A field fits its signed width only when all upper bits equal the sign.
  always_comb begin
    enc_inst = io_in_base;
    enc_err  = 1'b0;
    case (io_in_sel)
      SEL_I: begin
        enc_inst[31:20] = io_in_imm[11:0];
        enc_err = (|io_in_imm[31:11]) & ~(&io_in_imm[31:11]);
      end
      SEL_S: begin
        enc_inst[31:25] = io_in_imm[11:5];
        enc_inst[11:7]  = io_in_imm[4:0];
        enc_err = (|io_in_imm[31:11]) & ~(&io_in_imm[31:11]);
      end
      SEL_B: begin
        enc_inst[31]    = io_in_imm[12];
        enc_inst[30:25] = io_in_imm[10:5];
        enc_inst[11:8]  = io_in_imm[4:1];
        enc_inst[7]     = io_in_imm[11];
        enc_err = io_in_imm[0] | ((|io_in_imm[31:12]) & ~(&io_in_imm[31:12]));
      end
      SEL_U: begin
        enc_inst[31:12] = io_in_imm[31:12];
        enc_err = |io_in_imm[11:0];
      end
      SEL_J: begin
        enc_inst[31]    = io_in_imm[20];
        enc_inst[30:21] = io_in_imm[10:1];
        enc_inst[20]    = io_in_imm[11];
        enc_inst[19:12] = io_in_imm[19:12];
        enc_err = io_in_imm[0] | ((|io_in_imm[31:20]) & ~(&io_in_imm[31:20]));
      end
      SEL_Z: begin
        enc_inst[19:15] = io_in_imm[4:0];
        enc_err = |io_in_imm[31:5];
      end
      default: begin
        enc_inst = io_in_base;
        enc_err  = 1'b0;
      end
    endcase
  end

  assign io_in_ready  = (count_q < 2'd2) & ~io_flush;
  assign io_out_valid = (count_q != 2'd0);
  assign io_out_inst  = inst_q[rd_ptr_q];
  assign io_out_err   = err_q[rd_ptr_q];
  assign io_err_cnt   = err_cnt_q;
  assign push         = io_in_valid & io_in_ready;
  assign pop          = io_out_valid & io_out_ready;

  always_comb begin
    inst_d    = inst_q;
    err_d     = err_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    err_cnt_d = err_cnt_q;
    if (push) begin
      inst_d[wr_ptr_q] = enc_inst;
      err_d[wr_ptr_q]  = enc_err;
      wr_ptr_d         = ~wr_ptr_q;
      if (enc_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Flush blocks push via io_in_ready, so only occupancy needs clearing.
    if (io_flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst_q[0] <= 32'd0;
      inst_q[1] <= 32'd0;
      err_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      err_cnt_q <= 8'd0;
    end else begin
      inst_q    <= inst_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_enc.sv
`default_nettype none
// Bench for imm_enc: directed vectors plus randomized traffic against a
// queue-level reference model.
module tb_imm_enc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [31:0] io_in_base = 32'd0;
  logic [31:0] io_in_imm = 32'd0;
  logic [2:0]  io_in_sel = 3'd0;
  logic        io_flush = 1'b0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [31:0] io_out_inst;
  logic        io_out_err;
  logic [7:0]  io_err_cnt;

  imm_enc dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_base  (io_in_base),
    .io_in_imm   (io_in_imm),
    .io_in_sel   (io_in_sel),
    .io_flush    (io_flush),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_inst (io_out_inst),
    .io_out_err  (io_out_err),
    .io_err_cnt  (io_err_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [32:0] mq[$];   // {err, inst}, head at index 0
  int model_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder: field placement by mask/shift, range by signed limits.
  function automatic logic [32:0] ref_enc(input logic [31:0] b, input logic [31:0] im,
                                          input logic [2:0] s);
    int si;
    logic [31:0] r;
    logic e;
    si = signed'(im);
    r = b;
    e = 1'b0;
    case (s)
      3'd1: begin
        r = (b & 32'h000FFFFF) | ((im & 32'hFFF) << 20);
        e = (si < -2048) || (si > 2047);
      end
      3'd2: begin
        r = (b & 32'h01FFF07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
        e = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        r = (b & 32'h00000FFF) | (im & 32'hFFFFF000);
        e = (im & 32'hFFF) != 0;
      end
      3'd4: begin
        r = (b & 32'h00000FFF) | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
            | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12);
        e = (im[0] == 1'b1) || (si < -(1 << 20)) || (si > (1 << 20) - 1);
      end
      3'd5: begin
        r = (b & 32'h01FFF07F) | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
            | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
        e = (im[0] == 1'b1) || (si < -4096) || (si > 4095);
      end
      3'd6: begin
        r = (b & 32'hFFF07FFF) | ((im & 32'h1F) << 15);
        e = im > 32'd31;
      end
      default: begin
        r = b;
        e = 1'b0;
      end
    endcase
    return {e, r};
  endfunction

  // One clock cycle: drive at negedge, check against model, advance model.
  task automatic step(input logic v, input logic [31:0] b, input logic [31:0] im,
                      input logic [2:0] s, input logic fl, input logic ordy);
    logic acc, deq;
    logic [32:0] e;
    @(negedge clock);
    io_in_valid = v; io_in_base = b; io_in_imm = im; io_in_sel = s;
    io_flush = fl; io_out_ready = ordy;
    #1;
    chk("in_ready", {31'd0, io_in_ready}, {31'd0, (mq.size() < 2) && !fl});
    chk("out_valid", {31'd0, io_out_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("out_inst", io_out_inst, mq[0][31:0]);
      chk("out_err", {31'd0, io_out_err}, {31'd0, mq[0][32]});
    end
    chk("err_cnt", {24'd0, io_err_cnt}, 32'(model_cnt));
    acc = v && (mq.size() < 2) && !fl;
    deq = (mq.size() > 0) && ordy;
    e = ref_enc(b, im, s);
    if (deq) void'(mq.pop_front());
    if (fl) mq.delete();
    else if (acc) begin
      mq.push_back(e);
      if (e[32] && model_cnt < 255) model_cnt++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
  endtask

  // Single request into an empty FIFO, checked against literal values.
  task automatic vec(input string tag, input logic [31:0] b, input logic [31:0] im,
                     input logic [2:0] s, input logic [31:0] exp_inst, input logic exp_err);
    drain();
    step(1'b1, b, im, s, 1'b0, 1'b0);
    chk({tag, "_valid"}, {31'd0, io_out_valid}, 32'd1);
    chk({tag, "_inst"}, io_out_inst, exp_inst);
    chk({tag, "_err"}, {31'd0, io_out_err}, {31'd0, exp_err});
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] x;
    case ($urandom_range(0, 3))
      0: x = $urandom;
      1: x = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: x = $urandom & 32'hFFFFF000;
      default: x = 32'($urandom_range(0, 63));
    endcase
    return x;
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
    chk("rst_out_inst", io_out_inst, 32'd0);
    chk("rst_out_err", {31'd0, io_out_err}, 32'd0);
    chk("rst_err_cnt", {24'd0, io_err_cnt}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, io_in_ready}, 32'd1);

    // Directed encodings
    vec("I", 32'h00000013, 32'hFFFFFFFF, 3'd1, 32'hFFF00013, 1'b0);
    vec("S", 32'h00002023, 32'hFFFFFFFC, 3'd2, 32'hFE002E23, 1'b0);
    vec("B", 32'h00000063, 32'd8, 3'd5, 32'h00000463, 1'b0);
    vec("B_odd", 32'h00000063, 32'd7, 3'd5, 32'h00000363, 1'b1);
    chk("B_odd_cnt", {24'd0, io_err_cnt}, 32'd1);
    vec("J", 32'h0000006F, 32'h00000800, 3'd4, 32'h0010006F, 1'b0);
    vec("U", 32'h00000037, 32'h12345000, 3'd3, 32'h12345037, 1'b0);
    vec("U_err", 32'h00000037, 32'h12345001, 3'd3, 32'h12345037, 1'b1);
    vec("X0", 32'hDEADBEEF, 32'h12345678, 3'd0, 32'hDEADBEEF, 1'b0);
    vec("X7", 32'h00C0FFEE, 32'hFFFFFFFF, 3'd7, 32'h00C0FFEE, 1'b0);
    vec("Z", 32'h00000073, 32'd31, 3'd6, 32'h000F8073, 1'b0);
    vec("Z_err", 32'h00000073, 32'd32, 3'd6, 32'h00000073, 1'b1);
    vec("I_max", 32'h00000013, 32'd2047, 3'd1, 32'h7FF00013, 1'b0);
    vec("I_ovf", 32'h00000013, 32'd2048, 3'd1, 32'h80000013, 1'b1);

    // Backpressure: three offers, two accepted, then drain in order
    drain();
    step(1'b1, 32'h00000013, 32'd1, 3'd1, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'd2, 3'd1, 1'b0, 1'b0);
    chk("bp_full_ready", {31'd0, io_in_ready}, 32'd0);
    step(1'b1, 32'h00000013, 32'd3, 3'd1, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'd3, 3'd1, 1'b0, 1'b1);
    step(1'b1, 32'h00000013, 32'd3, 3'd1, 1'b0, 1'b1);
    chk("bp_third_inst", io_out_inst, 32'h00300013);
    drain();

    // Flush with two queued entries
    step(1'b1, 32'h00000063, 32'd5, 3'd5, 1'b0, 1'b0);
    step(1'b1, 32'h00000063, 32'd6, 3'd5, 1'b0, 1'b0);
    step(1'b1, 32'h00000063, 32'd9, 3'd5, 1'b1, 1'b0);
    chk("flush_valid", {31'd0, io_out_valid}, 32'd0);
    step(1'b1, 32'h00000013, 32'd4, 3'd1, 1'b0, 1'b1);
    step(1'b1, 32'h00000013, 32'd5, 3'd1, 1'b1, 1'b1);
    drain();

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) step(1'b1, 32'h00000073, 32'h00000100, 3'd6, 1'b0, 1'b1);
    chk("sat_cnt", {24'd0, io_err_cnt}, 32'd255);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, rand_imm(), 3'($urandom_range(0, 7)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset with one entry queued
    drain();
    step(1'b1, 32'h00000013, 32'd7, 3'd1, 1'b0, 1'b0);
    io_in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, io_out_valid}, 32'd0);
    chk("arst_inst", io_out_inst, 32'd0);
    chk("arst_cnt", {24'd0, io_err_cnt}, 32'd0);
    mq.delete();
    model_cnt = 0;
    @(negedge clock);
    reset = 1'b1;
    vec("post_rst", 32'h00000013, 32'hFFFFF800, 3'd1, 32'h80000013, 1'b0);
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
